// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional parity bit and a
// stop period of SB_TICK ticks. Timing follows a 16x oversampling s_tick enable.
module uart_tx #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            s_tick_i,
  input  logic            tx_start_i,
  input  logic [DBIT-1:0] din_i,
  output logic            tx_o,
  output logic            tx_busy_o,
  output logic            tx_done_tick_o
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [4:0] BitLast  = 5'd15;
  localparam logic [4:0] StopLast = 5'(SB_TICK - 1);
  localparam logic [2:0] NLast    = 3'(DBIT - 1);
  localparam logic       ParOdd   = (PARITY_ODD != 0);
  localparam logic       ParEn    = (PARITY_EN != 0);

  state_e          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done;

  // Next-state logic for the frame sequencer plus the line level of the next state.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_start_i) begin
          b_d     = din_i;
          par_d   = (^din_i) ^ ParOdd;
          s_d     = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (s_tick_i) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            n_d     = '0;
            state_d = StData;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (s_tick_i) begin
          if (s_q == BitLast) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NLast) begin
              state_d = ParEn ? StParity : StStop;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StParity: begin
        if (s_tick_i) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (s_tick_i) begin
          if (s_q == StopLast) begin
            state_d = StIdle;
            done    = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Registering the next state's level keeps the pad glitch-free.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = b_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset abandons any partial frame and forces the line idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Outputs: registered line, status and end-of-frame pulse.
  always_comb begin
    tx_o           = tx_q;
    tx_busy_o      = (state_q != StIdle);
    tx_done_tick_o = done;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: several configurations, a per-tick reference frame model and a
// scoreboard that compares each completed frame as seen on the line.
module tb_uart_tx;

  localparam int NDUT = 5;

  function automatic int cfg_dbit(int i);
    case (i)
      3:       return 7;
      4:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_sb(int i);
    case (i)
      3:       return 32;
      4:       return 24;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_pen(int i);
    return (i == 1 || i == 2 || i == 4) ? 1 : 0;
  endfunction

  function automatic int cfg_odd(int i);
    return (i == 2 || i == 4) ? 1 : 0;
  endfunction

  typedef struct {
    int           idx;
    int           len;
    logic [255:0] bits;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_tick;
  logic [NDUT-1:0] start;
  logic [NDUT-1:0] tx;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] done;
  logic [7:0]      din [NDUT];

  int           checks = 0;
  int           errors = 0;
  frame_t       exp_q[$];
  int           acc_len [NDUT];
  logic [255:0] acc_bits [NDUT];
  bit           rand_ticks = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int DB = cfg_dbit(g);
    uart_tx #(
      .DBIT      (DB),
      .SB_TICK   (cfg_sb(g)),
      .PARITY_EN (cfg_pen(g)),
      .PARITY_ODD(cfg_odd(g))
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .s_tick_i      (s_tick),
      .tx_start_i    (start[g]),
      .din_i         (din[g][DB-1:0]),
      .tx_o          (tx[g]),
      .tx_busy_o     (busy[g]),
      .tx_done_tick_o(done[g])
    );
  end

  // Reference: line level at each baud tick of one frame.
  function automatic frame_t model(int i, logic [7:0] data);
    frame_t f;
    logic   p;
    int     pos;
    f.idx  = i;
    f.bits = '0;
    pos    = 16;  // start bit: 16 ticks of zero
    p      = (cfg_odd(i) != 0);
    for (int k = 0; k < cfg_dbit(i); k++) p = p ^ data[k];
    for (int k = 0; k < cfg_dbit(i); k++) begin
      for (int t = 0; t < 16; t++) begin
        f.bits[pos] = data[k];
        pos++;
      end
    end
    if (cfg_pen(i) != 0) begin
      for (int t = 0; t < 16; t++) begin
        f.bits[pos] = p;
        pos++;
      end
    end
    for (int t = 0; t < cfg_sb(i); t++) begin
      f.bits[pos] = 1'b1;
      pos++;
    end
    f.len = pos;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: collect the line value at every tick while busy; compare on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        acc_len[i]  = 0;
        acc_bits[i] = '0;
      end
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        if (busy[i]) begin
          if (s_tick && acc_len[i] < 256) begin
            acc_bits[i][acc_len[i]] = tx[i];
            acc_len[i]++;
          end
        end else begin
          checks++;
          if (tx[i] !== 1'b1) begin
            errors++;
            $display("FAIL idle_high dut=%0d actual=%b required=1", i, tx[i]);
          end
          if (acc_len[i] != 0 && !done[i]) begin
            errors++;
            $display("FAIL frame_cut dut=%0d actual_ticks=%0d required=done_pulse", i,
                     acc_len[i]);
            acc_len[i]  = 0;
            acc_bits[i] = '0;
          end
        end
        if (done[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut=%0d actual=pulse required=none", i);
          end else begin
            frame_t e;
            e = exp_q.pop_front();
            chk("frame_dut", i, e.idx);
            chk("frame_len", acc_len[i], e.len);
            checks++;
            if (acc_bits[i] !== e.bits) begin
              errors++;
              $display("FAIL frame_bits dut=%0d actual=%h required=%h", i, acc_bits[i],
                       e.bits);
            end
          end
          acc_len[i]  = 0;
          acc_bits[i] = '0;
        end
      end
    end
  end

  // Baud enable: every 4th clk, or random spacing when rand_ticks is set.
  initial begin
    int div;
    div    = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ticks) begin
        s_tick = ($urandom_range(0, 2) == 0);
      end else begin
        div    = (div + 1) % 4;
        s_tick = (div == 0);
      end
    end
  end

  task automatic send(input int i, input logic [7:0] data);
    @(posedge clk);
    #1;
    start[i] = 1'b1;
    din[i]   = data;
    exp_q.push_back(model(i, data));
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    din[i]   = 8'($urandom);
    chk("start_line_low", tx[i], 0);
    chk("start_busy", busy[i], 1);
  endtask

  task automatic wait_done(input int i);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 20000 && !found; n++) begin
      @(negedge clk);
      if (done[i]) found = 1'b1;
    end
    chk("done_seen", found, 1);
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(negedge clk);
      if (s_tick) c++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < NDUT; i++) din[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_tx", tx[i], 1);
      chk("reset_busy", busy[i], 0);
      chk("reset_done", done[i], 0);
    end
    #2;
    rst_n = 1'b1;

    // Directed frames across configurations.
    send(0, 8'hA5); wait_done(0);
    send(1, 8'hA5); wait_done(1);
    send(2, 8'hA5); wait_done(2);
    send(1, 8'h07); wait_done(1);
    send(3, 8'h55); wait_done(3);
    send(4, 8'h13); wait_done(4);

    // Start while busy is ignored.
    send(0, 8'hA5);
    wait_ticks(16 * 3 + 5);
    @(posedge clk); #1;
    start[0] = 1'b1;
    din[0]   = 8'hFF;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(0);

    // Back-to-back: start held from the final stop clk; only the next clk accepts it.
    send(0, 8'h5A);
    wait_done(0);
    start[0] = 1'b1;
    din[0]   = 8'h3C;
    exp_q.push_back(model(0, 8'h3C));
    @(posedge clk); #1;
    chk("b2b_idle_busy", busy[0], 0);
    chk("b2b_idle_tx", tx[0], 1);
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("b2b_start_tx", tx[0], 0);
    chk("b2b_start_busy", busy[0], 1);
    wait_done(0);

    // Reset during data bit 3.
    send(0, 8'hC3);
    wait_ticks(16 * 4 + 8);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete(exp_q.size() - 1);
    #1;
    chk("rst_mid_tx", tx[0], 1);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_done", done[0], 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    send(0, 8'h81); wait_done(0);

    // Randomised frames with irregular tick spacing and spurious starts.
    rand_ticks = 1'b1;
    for (int r = 0; r < 20; r++) begin
      int i;
      i = $urandom_range(0, NDUT - 1);
      send(i, 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        wait_ticks($urandom_range(1, 100));
        @(posedge clk); #1;
        start[i] = 1'b1;
        din[i]   = 8'($urandom);
        @(posedge clk); #1;
        start[i] = 1'b0;
      end
      wait_done(i);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. Pairs with the existing oversampling UART receiver and uses the same s_tick baud-rate enable (16 ticks per bit).
- Accepts a DBIT-wide word on a one-cycle tx_start strobe and shifts it out LSB-first.
- Frame: start bit (0), DBIT data bits, optional parity bit, stop period (1) of SB_TICK ticks.
- Pulses tx_done_tick when the frame completes. Sits between the baud generator / TX FIFO and the pad.

Parameters:
- DBIT, 8, data bits per frame; legal range 5..8.
- SB_TICK, 16, ticks in the stop period; 16/24/32 give 1/1.5/2 stop bits.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- s_tick  input  1  baud enable, one-clk pulse, 16 per bit period.
- tx_start  input  1  one-clk strobe requesting transmission of din.
- din  input  DBIT  word to send; sampled only on an accepted tx_start.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high whenever state is not IDLE.
- tx_done_tick  output  1  one-clk pulse at end of the stop period.

Behaviour:
- Registers:
  - state: 3 bits.
  - s: 5-bit tick counter.
  - n: 3-bit bit counter.
  - b: DBIT-bit shift register.
  - par: 1-bit parity.
  - tx_reg: 1 bit.
- Reset (reset=0, asynchronous, any time including mid-frame):
  - state=IDLE, s=0, n=0, b=0, par=0.
  - tx=1 immediately; tx_busy=0, tx_done_tick=0.
  - A partial frame is abandoned; no done pulse.
- tx is driven from tx_reg, which is loaded every clk with the line value of the next state. It never glitches.
- IDLE:
  - tx=1.
  - tx_start=1 → b=din; par=^din XOR PARITY_ODD; s=0; next=START.
  - tx falls to 0 on the same edge.
- START:
  - tx=0.
  - On s_tick: if s==15 → s=0, n=0, next=DATA; else s=s+1.
  - Bit lasts 16 ticks counted from the first s_tick after entry.
- DATA:
  - tx=b[0].
  - On s_tick with s==15: s=0, b=b>>1.
    - If n==DBIT-1 → next=PARITY if PARITY_EN, else STOP.
    - Otherwise n=n+1.
  - On s_tick with s<15: s=s+1.
- PARITY (PARITY_EN=1 only):
  - tx=par.
  - On s_tick: if s==15 → s=0, next=STOP; else s=s+1.
- STOP:
  - tx=1.
  - On s_tick: if s==SB_TICK-1 → next=IDLE, tx_done_tick=1 in that clk only; else s=s+1.
- tx_done_tick is combinational from state/s/s_tick and is high for exactly one clk per completed frame.
- Simultaneous events and boundary cases:
  - tx_start while tx_busy=1 is ignored. din changes during a frame do not affect it.
  - tx_start in the same clk as the final STOP tick is ignored. It is accepted in IDLE on the following clk or later.
  - Back-to-back frames: tx_start in the first IDLE clk after tx_done_tick yields a stop period of exactly SB_TICK ticks, then an immediate start bit.
  - s_tick=0 freezes all counters; the state holds indefinitely.
  - Counters are sized for max values 31 (s) and 7 (n); no wrap occurs within legal parameter ranges.
  - Frame length is 16·(1+DBIT+PARITY_EN)+SB_TICK ticks.

Test Plan:
- Single frame, defaults, s_tick every 4 clk, din=8'hA5:
  - tx = 0 for 64 clk, then 1,0,1,0,0,1,0,1 at 64 clk each, then 1 for 64 clk.
  - tx_done_tick pulses once; tx_busy is high throughout the frame.
- PARITY_EN=1, din=8'hA5:
  - Even (PARITY_ODD=0): parity bit 0.
  - Odd (PARITY_ODD=1): parity bit 1.
  - din=8'h07 even: parity bit 1.
  - Frame is 12·16-16+... i.e. 176 ticks total with SB_TICK=16.
- Start ignored while busy: second tx_start with din=8'hFF mid-DATA → line still shows 8'hA5; exactly one tx_done_tick.
- Back-to-back: tx_start=1 on the clk after tx_done_tick, din=8'h3C → stop period exactly 16 ticks, then the start bit. Loopback into the UART receiver gives dout=8'h3C and rx_done_tick.
- Reset mid-frame: drive reset=0 during DATA bit 3 → tx=1 asynchronously, tx_busy=0, no tx_done_tick. After release, a new frame with 8'h81 transmits correctly.
- SB_TICK=32, DBIT=7, din=7'h55: stop level lasts 32 ticks; total frame 16·8+32=160 ticks.
